// File: rtl/regfile_pkg.sv
// Purpose : shared defaults, word/address typedefs and constants for the register file.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int DATA_WIDTH_DEF   = 32;
   localparam int ADDR_WIDTH_DEF   = 3;
   localparam int NUM_RD_PORTS_DEF = 2;

   typedef logic [DATA_WIDTH_DEF-1:0] word_t;
   typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

   localparam word_t ZERO_WORD = '0;

endpackage

// File: rtl/regfile_read_port.sv
// Purpose : one registered read port: address mux, write-first bypass compare, rdata/rvalid flops.
// Latency : one cycle from accepted read (re=1 at edge N) to rdata/rvalid valid after edge N.
// Backpressure: none; a read is accepted on every edge with re=1, rdata holds while re=0.
// Ports   : clk, rst (async active-high), re/raddr (this port's request), we/waddr/wdata (write
//           port snoop for bypass), mem (flattened storage), rdata/rvalid (registered result).
// Option  : REGFILE_ZERO_REG_EN makes address 0 always read as zero.
module regfile_read_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      re,
   input  logic [ADDR_WIDTH-1:0]                     raddr,
   input  logic                                      we,
   input  logic [ADDR_WIDTH-1:0]                     waddr,
   input  logic [DATA_WIDTH-1:0]                     wdata,
   input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] mem,
   output logic [DATA_WIDTH-1:0]                     rdata,
   output logic                                      rvalid
);

   logic [DATA_WIDTH-1:0] next_data;

   always_comb begin
      next_data = mem[raddr];
      // Write-first: a same-edge write to the address being read wins over stale storage.
      if (we && (waddr == raddr)) begin
         next_data = wdata;
      end
`ifdef REGFILE_ZERO_REG_EN
      // Zero register overrides everything, including a bypassed write to address 0.
      if (raddr == '0) begin
         next_data = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) begin
            rdata <= next_data;
         end
      end
   end

endmodule

// File: rtl/multi_port_register_file.sv
// Purpose : DEPTH x DATA_WIDTH register file, one synchronous write port, NUM_RD_PORTS registered
//           read ports with write-first bypass; sits between decode and the ALU operand latches.
// Latency : write visible to ordinary reads from the following edge; reads return one cycle later.
// Backpressure: none; reads and writes are accepted on every edge with rst low.
// Ports   : clk, rst (async active-high), we/waddr/wdata (write port), re/raddr (packed per-port
//           read requests, port i at slice i), rdata/rvalid (packed per-port registered results).
// Option  : REGFILE_ZERO_REG_EN hardwires address 0 to zero (writes to it are discarded).
module multi_port_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int NUM_RD_PORTS = NUM_RD_PORTS_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               we,
   input  logic [ADDR_WIDTH-1:0]              waddr,
   input  logic [DATA_WIDTH-1:0]              wdata,
   input  logic [NUM_RD_PORTS-1:0]            re,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rdata,
   output logic [NUM_RD_PORTS-1:0]            rvalid
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic                             wr_en;

`ifdef REGFILE_ZERO_REG_EN
   // Word 0 is never written, so it stays at its reset value of zero.
   assign wr_en = we && (waddr != '0);
`else
   assign wr_en = we;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '0;
      end else if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   // Ports snoop the raw write request; the zero-register override inside the port
   // covers the discarded write to address 0.
   for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
      regfile_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_rd (
         .clk    (clk),
         .rst    (rst),
         .re     (re[i]),
         .raddr  (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .we     (we),
         .waddr  (waddr),
         .wdata  (wdata),
         .mem    (mem),
         .rdata  (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
         .rvalid (rvalid[i])
      );
   end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Purpose : directed self-checking bench for multi_port_register_file (default 8x32, 2 read ports).
// Latency : n/a.
// Backpressure: n/a.
module tb_multi_port_register_file;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [2:0]  waddr;
   logic [31:0] wdata;
   logic [1:0]  re;
   logic [5:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rvalid;

   int vectors = 0;
   int miscompares = 0;

   word_t wv [8];
   word_t exp_w;

   multi_port_register_file dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re     (re),
      .raddr  (raddr),
      .rdata  (rdata),
      .rvalid (rvalid)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      wv[0] = 32'h12345678; wv[1] = 32'h13579bdf; wv[2] = 32'habcdef82; wv[3] = 32'h2385065d;
      wv[4] = 32'haaabbccd; wv[5] = 32'hffff222d; wv[6] = 32'h113239dc; wv[7] = 32'hccccffff;

      // Reset, with write/read requests that must be ignored while rst is high.
      rst = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 32'hdeadbeef; re = 2'b11; raddr = {3'd2, 3'd2};
      tick;
      check("reset_rdata", rdata, 64'h0);
      check("reset_rvalid", 64'(rvalid), 64'h0);
      tick;
      rst = 1'b0; we = 1'b0; re = 2'b00;
      tick;
      check("post_reset_rvalid", 64'(rvalid), 64'h0);

      // Write sweep.
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; waddr = 3'(i); wdata = wv[i];
         tick;
      end
      we = 1'b0;

      // Read sweep on port 0, back-to-back.
      for (int i = 0; i < 8; i++) begin
         re = 2'b01; raddr = {3'd0, 3'(i)};
         tick;
`ifdef REGFILE_ZERO_REG_EN
         exp_w = (i == 0) ? 32'h0 : wv[i];
`else
         exp_w = wv[i];
`endif
         check($sformatf("sweep_rdata0_a%0d", i), 64'(rdata[31:0]), 64'(exp_w));
         check($sformatf("sweep_rvalid_a%0d", i), 64'(rvalid), 64'h1);
      end
      re = 2'b00;
      tick;
      check("sweep_rvalid_drop", 64'(rvalid), 64'h0);

      // Dual port, same address, then port 1 alone.
      re = 2'b11; raddr = {3'd3, 3'd3};
      tick;
      check("dual_rdata0", 64'(rdata[31:0]), 64'h2385065d);
      check("dual_rdata1", 64'(rdata[63:32]), 64'h2385065d);
      check("dual_rvalid", 64'(rvalid), 64'h3);
      re = 2'b10; raddr = {3'd6, 3'd3};
      tick;
      check("dual_next_rdata1", 64'(rdata[63:32]), 64'h113239dc);
      check("dual_next_rdata0_hold", 64'(rdata[31:0]), 64'h2385065d);
      check("dual_next_rvalid", 64'(rvalid), 64'h2);

      // Write-first bypass on both ports.
      we = 1'b1; waddr = 3'd5; wdata = 32'hdeadbeef; re = 2'b11; raddr = {3'd5, 3'd5};
      tick;
      check("bypass_rdata0", 64'(rdata[31:0]), 64'hdeadbeef);
      check("bypass_rdata1", 64'(rdata[63:32]), 64'hdeadbeef);
      we = 1'b0; re = 2'b01; raddr = {3'd0, 3'd5};
      tick;
      check("after_bypass_rdata0", 64'(rdata[31:0]), 64'hdeadbeef);
      check("after_bypass_rvalid", 64'(rvalid), 64'h1);

      // Hold for three idle cycles.
      re = 2'b01; raddr = {3'd0, 3'd4};
      tick;
      check("hold_load", 64'(rdata[31:0]), 64'haaabbccd);
      re = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("hold_rdata_c%0d", i), 64'(rdata[31:0]), 64'haaabbccd);
         check($sformatf("hold_rvalid_c%0d", i), 64'(rvalid), 64'h0);
      end

      // Reset mid-cycle with a read in flight and a write pending.
      re = 2'b11; raddr = {3'd1, 3'd7};
      tick;
      check("pre_reset_rvalid", 64'(rvalid), 64'h3);
      check("pre_reset_rdata", rdata, {32'h13579bdf, 32'hccccffff});
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_rdata", rdata, 64'h0);
      check("async_reset_rvalid", 64'(rvalid), 64'h0);
      we = 1'b1; waddr = 3'd3; wdata = 32'h55555555;
      tick;
      rst = 1'b0; we = 1'b0; re = 2'b00;
      for (int i = 0; i < 8; i++) begin
         re = 2'b10; raddr = {3'(i), 3'd0};
         tick;
         check($sformatf("cleared_rdata1_a%0d", i), 64'(rdata[63:32]), 64'h0);
         check($sformatf("cleared_rvalid_a%0d", i), 64'(rvalid), 64'h2);
      end
      re = 2'b00;

      // Address 0: zero register when enabled, ordinary word otherwise.
`ifdef REGFILE_ZERO_REG_EN
      exp_w = 32'h0;
`else
      exp_w = 32'hffffffff;
`endif
      we = 1'b1; waddr = 3'd0; wdata = 32'hffffffff; re = 2'b01; raddr = {3'd0, 3'd0};
      tick;
      check("addr0_bypass_rdata0", 64'(rdata[31:0]), 64'(exp_w));
      check("addr0_bypass_rvalid", 64'(rvalid), 64'h1);
      we = 1'b0; re = 2'b10; raddr = {3'd0, 3'd0};
      tick;
      check("addr0_later_rdata1", 64'(rdata[63:32]), 64'(exp_w));
      check("addr0_later_rvalid", 64'(rvalid), 64'h2);
      re = 2'b00;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
